// File: rtl/auv_pkg.sv
// rtl/auv_pkg.sv - shared types for the auv core bus fabric
package auv_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN_I = 2'd1,
    ARB_OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_M_I = 1'b0,
    ARB_M_D = 1'b1
  } arb_master_t;

endpackage

// File: rtl/auv_wb_watchdog.sv
// rtl/auv_wb_watchdog.sv - bus watchdog that expires a cycle stuck without ACK/ERR
module auv_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic done,
  output logic expire
);

  // TIMEOUT=0 disables the watchdog; keep a 1-bit counter so the logic stays legal
  localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT = LIM[CW-1:0];

  logic [CW-1:0] count;
  logic          waiting;

  assign waiting = busy & ~done;
  // The current wait cycle is number count+1, so expiry fires on the TIMEOUT-th wait cycle
  assign expire  = (TIMEOUT > 0) && waiting && (count == LIMIT);

  // Count unanswered bus cycles; clear on response, expiry, or loss of ownership
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!waiting || expire || TIMEOUT == 0) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/auv_wb_arbiter.sv
// rtl/auv_wb_arbiter.sv - CYC-locked round-robin Wishbone arbiter for fetch (I) and load/store (D)
module auv_wb_arbiter
  import auv_pkg::*;
#(
  parameter int ADDR_WIDTH = 24,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] mi_adr_i,
  output logic [15:0]           mi_dat_o,
  input  logic [1:0]            mi_sel_i,
  input  logic                  mi_stb_i,
  input  logic                  mi_cyc_i,
  output logic                  mi_ack_o,
  output logic                  mi_stall_o,
  output logic                  mi_err_o,
  input  logic [ADDR_WIDTH-1:0] md_adr_i,
  output logic [15:0]           md_dat_o,
  input  logic [15:0]           md_dat_i,
  input  logic [1:0]            md_sel_i,
  input  logic                  md_we_i,
  input  logic                  md_stb_i,
  input  logic                  md_cyc_i,
  output logic                  md_ack_o,
  output logic                  md_stall_o,
  output logic                  md_err_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [15:0]           s_dat_o,
  output logic [1:0]            s_sel_o,
  output logic                  s_we_o,
  output logic                  s_stb_o,
  output logic                  s_cyc_o,
  input  logic [15:0]           s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_stall_i,
  input  logic                  s_err_i
);

  arb_state_t  state;
  arb_master_t last;
  logic        idle_i, idle_d;
  logic        sel_i, sel_d;
  logic        expire;

  // In IDLE a lone requester wins; on contention the master that did not own last wins
  assign idle_i = mi_cyc_i & (~md_cyc_i | (last == ARB_M_D));
  assign idle_d = md_cyc_i & (~mi_cyc_i | (last == ARB_M_I));

  // Zero-latency grant from IDLE, otherwise the owner keeps the bus while its CYC stays high
  assign sel_i = rst_n & (((state == ARB_IDLE) & idle_i) | ((state == ARB_OWN_I) & mi_cyc_i));
  assign sel_d = rst_n & (((state == ARB_IDLE) & idle_d) | ((state == ARB_OWN_D) & md_cyc_i));

  // Track the owner for the next cycle and remember who owned most recently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
      last  <= ARB_M_I;
    end else if (sel_i) begin
      state <= ARB_OWN_I;
      last  <= ARB_M_I;
    end else if (sel_d) begin
      state <= ARB_OWN_D;
      last  <= ARB_M_D;
    end else begin
      state <= ARB_IDLE;
    end
  end

  auv_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .busy   (sel_i | sel_d),
    .done   (s_ack_i | s_err_i),
    .expire (expire)
  );

  // Owner request mux towards the slave; I never writes, so write data comes from D only
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_stb_o = 1'b0;
    s_cyc_o = 1'b0;
    if (sel_i) begin
      s_adr_o = mi_adr_i;
      s_sel_o = mi_sel_i;
      s_stb_o = mi_stb_i & ~expire;
      s_cyc_o = ~expire;
    end else if (sel_d) begin
      s_adr_o = md_adr_i;
      s_dat_o = md_dat_i;
      s_sel_o = md_sel_i;
      s_we_o  = md_we_i;
      s_stb_o = md_stb_i & ~expire;
      s_cyc_o = ~expire;
    end
  end

  // Slave responses go straight to the owner; everyone else sees stall and no ack/err
  assign mi_ack_o   = sel_i & s_ack_i;
  assign mi_err_o   = sel_i & (s_err_i | expire);
  assign mi_stall_o = ~sel_i | s_stall_i | expire;
  assign md_ack_o   = sel_d & s_ack_i;
  assign md_err_o   = sel_d & (s_err_i | expire);
  assign md_stall_o = ~sel_d | s_stall_i | expire;
  assign mi_dat_o   = s_dat_i;
  assign md_dat_o   = s_dat_i;

endmodule

// File: tb/tb_auv_wb_arbiter.sv
// tb/tb_auv_wb_arbiter.sv - directed self-checking bench for auv_wb_arbiter
module tb_auv_wb_arbiter;

  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mi_adr_i, md_adr_i, s_adr_o;
  logic [15:0]   mi_dat_o, md_dat_o, md_dat_i, s_dat_o, s_dat_i;
  logic [1:0]    mi_sel_i, md_sel_i, s_sel_o;
  logic          md_we_i, mi_stb_i, mi_cyc_i, md_stb_i, md_cyc_i;
  logic          mi_ack_o, mi_stall_o, mi_err_o, md_ack_o, md_stall_o, md_err_o;
  logic          s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_stall_i, s_err_i;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  auv_wb_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mi_adr_i(mi_adr_i), .mi_dat_o(mi_dat_o), .mi_sel_i(mi_sel_i),
    .mi_stb_i(mi_stb_i), .mi_cyc_i(mi_cyc_i),
    .mi_ack_o(mi_ack_o), .mi_stall_o(mi_stall_o), .mi_err_o(mi_err_o),
    .md_adr_i(md_adr_i), .md_dat_o(md_dat_o), .md_dat_i(md_dat_i), .md_sel_i(md_sel_i),
    .md_we_i(md_we_i), .md_stb_i(md_stb_i), .md_cyc_i(md_cyc_i),
    .md_ack_o(md_ack_o), .md_stall_o(md_stall_o), .md_err_o(md_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_stall_i(s_stall_i), .s_err_i(s_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mi_adr_i = 24'h00A000; md_adr_i = 24'h001234; md_dat_i = '0; s_dat_i = '0;
    mi_sel_i = 2'b11; md_sel_i = 2'b11; md_we_i = 0;
    mi_stb_i = 0; mi_cyc_i = 0; md_stb_i = 0; md_cyc_i = 1;
    s_ack_i = 0; s_stall_i = 0; s_err_i = 0;

    // reset: grant gated even with a request present
    #3;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_adr", s_adr_o, 0);
    chk("rst_mi_stall", mi_stall_o, 1);
    chk("rst_md_stall", md_stall_o, 1);
    chk("rst_md_ack", md_ack_o, 0);
    md_cyc_i = 0;
    tick; rst_n = 1'b1;

    // D-only read with ACK after two cycles
    tick; md_cyc_i = 1; md_stb_i = 1; #2;
    chk("d_rd_cyc", s_cyc_o, 1);
    chk("d_rd_adr", s_adr_o, 32'h001234);
    chk("d_rd_md_stall", md_stall_o, 0);
    chk("d_rd_mi_stall0", mi_stall_o, 1);
    tick; md_stb_i = 0; #2;
    chk("d_rd_noack", md_ack_o, 0);
    tick; s_ack_i = 1; s_dat_i = 16'hBEEF; #2;
    chk("d_rd_ack", md_ack_o, 1);
    chk("d_rd_dat", md_dat_o, 16'hBEEF);
    chk("d_rd_mi_dat", mi_dat_o, 16'hBEEF);
    chk("d_rd_mi_stall1", mi_stall_o, 1);
    chk("d_rd_mi_ack", mi_ack_o, 0);
    tick; md_cyc_i = 0; s_ack_i = 0; #2;
    chk("d_rd_release", s_cyc_o, 0);

    // contention from reset: D wins, then I after one idle cycle
    rst_n = 1'b0; tick; rst_n = 1'b1;
    tick; mi_cyc_i = 1; mi_stb_i = 1; md_cyc_i = 1; md_stb_i = 1; #2;
    chk("cont_adr_d", s_adr_o, 32'h001234);
    chk("cont_md_stall", md_stall_o, 0);
    chk("cont_mi_stall", mi_stall_o, 1);
    tick; md_cyc_i = 0; md_stb_i = 0; #2;
    chk("cont_gap_cyc", s_cyc_o, 0);
    chk("cont_gap_mi_stall", mi_stall_o, 1);
    tick; #2;
    chk("cont_i_cyc", s_cyc_o, 1);
    chk("cont_i_adr", s_adr_o, 32'h00A000);
    chk("cont_i_stall", mi_stall_o, 0);
    tick; mi_cyc_i = 0; mi_stb_i = 0; #2;
    chk("cont_i_release", s_cyc_o, 0);

    // two-beat D write under one CYC while I keeps requesting
    tick; md_cyc_i = 1; md_stb_i = 1; md_we_i = 1; md_dat_i = 16'hA5A5;
    mi_cyc_i = 1; mi_stb_i = 1; s_ack_i = 1; #2;
    chk("wl_b1_we", s_we_o, 1);
    chk("wl_b1_dat", s_dat_o, 16'hA5A5);
    chk("wl_b1_ack", md_ack_o, 1);
    chk("wl_b1_mi_ack", mi_ack_o, 0);
    chk("wl_b1_mi_stall", mi_stall_o, 1);
    tick; md_stb_i = 0; s_ack_i = 0; #2;
    chk("wl_settle_cyc", s_cyc_o, 1);
    chk("wl_settle_stb", s_stb_o, 0);
    chk("wl_settle_mi_stall", mi_stall_o, 1);
    tick; md_stb_i = 1; md_adr_i = 24'h001236; s_ack_i = 1; #2;
    chk("wl_b2_adr", s_adr_o, 32'h001236);
    chk("wl_b2_stb", s_stb_o, 1);
    chk("wl_b2_ack", md_ack_o, 1);
    tick; md_cyc_i = 0; md_stb_i = 0; md_we_i = 0; s_ack_i = 0; #2;
    chk("wl_drop_cyc", s_cyc_o, 0);
    chk("wl_drop_mi_stall", mi_stall_o, 1);

    // watchdog: I granted now, slave silent; err on 4th wait cycle
    tick; #2;
    chk("wd_w1_adr", s_adr_o, 32'h00A000);
    chk("wd_w1_err", mi_err_o, 0);
    tick; #2;
    chk("wd_w2_err", mi_err_o, 0);
    tick; #2;
    chk("wd_w3_err", mi_err_o, 0);
    chk("wd_w3_cyc", s_cyc_o, 1);
    tick; #2;
    chk("wd_w4_err", mi_err_o, 1);
    chk("wd_w4_cyc", s_cyc_o, 0);
    chk("wd_w4_stb", s_stb_o, 0);
    chk("wd_w4_md_err", md_err_o, 0);
    tick; #2;
    chk("wd_w5_err", mi_err_o, 0);
    chk("wd_w5_cyc", s_cyc_o, 1);
    tick; mi_cyc_i = 0; mi_stb_i = 0;

    // ACK coincident with expiry: ACK wins
    tick; mi_cyc_i = 1; mi_stb_i = 1; #2;
    chk("wa_w1_cyc", s_cyc_o, 1);
    tick; tick; tick; s_ack_i = 1; #2;
    chk("wa_w4_ack", mi_ack_o, 1);
    chk("wa_w4_err", mi_err_o, 0);
    chk("wa_w4_cyc", s_cyc_o, 1);
    tick; mi_cyc_i = 0; mi_stb_i = 0; s_ack_i = 0;

    // reset while D owns mid-STB, then contention must go to D
    tick; md_cyc_i = 1; md_stb_i = 1; md_adr_i = 24'h0000C0;
    tick; #2;
    chk("mr_own_cyc", s_cyc_o, 1);
    rst_n = 1'b0; #1;
    chk("mr_cyc", s_cyc_o, 0);
    chk("mr_mi_stall", mi_stall_o, 1);
    chk("mr_md_stall", md_stall_o, 1);
    mi_cyc_i = 1; mi_stb_i = 1;
    tick; rst_n = 1'b1; #2;
    chk("mr_cont_adr", s_adr_o, 32'h0000C0);
    chk("mr_cont_md_stall", md_stall_o, 0);
    chk("mr_cont_mi_stall", mi_stall_o, 1);
    tick; mi_cyc_i = 0; mi_stb_i = 0; md_cyc_i = 0; md_stb_i = 0;
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/auv_wb_arbiter.md
# auv_wb_arbiter

Two-master, one-slave Wishbone arbiter that shares the core's single 16-bit Wishbone port between instruction fetch (master I) and the execute stage load/store unit (master D). It sits between the core stages and the external bus, and holds ownership for a whole bus cycle (CYC-locked), so multi-beat accesses are never split. Arbitration is round-robin with data priority on a tie-free start. A bus watchdog terminates any slave that never acknowledges.

## Interface
- ADDR_WIDTH, 24, byte address width of all address ports
- TIMEOUT, 255, cycles without ACK/ERR before watchdog abort; 0 disables the watchdog
- clk  in  1  core clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- mi_adr_i / md_adr_i  in  ADDR_WIDTH  master I / D address
- mi_dat_o / md_dat_o  out  16  read data to master
- md_dat_i  in  16  write data from D (I is read-only; slave write data comes from D only)
- mi_sel_i / md_sel_i  in  2  byte selects
- md_we_i  in  1  write enable from D (I always reads)
- mi_stb_i, mi_cyc_i / md_stb_i, md_cyc_i  in  1  strobe / cycle
- mi_ack_o, mi_stall_o, mi_err_o / md_ack_o, md_stall_o, md_err_o  out  1  per-master responses
- s_adr_o  out  ADDR_WIDTH; s_dat_o  out  16; s_sel_o  out  2; s_we_o, s_stb_o, s_cyc_o  out  1  to slave
- s_dat_i  in  16; s_ack_i, s_stall_i, s_err_i  in  1  from slave

## Operation
- States: IDLE, OWN_I, OWN_D. Register `last` records the most recent owner.
- IDLE: combinational grant in the same cycle as the request.
  - Only one CYC high: that master is granted.
  - Both high: the master that is not `last` is granted.
  - The granted master's signals pass to the slave immediately, and the state moves to the owner at the next edge. The execute stage needs this zero-latency grant, because it issues STB combinationally and advances on ~stall.
- OWN_x: owner's signals are muxed to the slave; slave ACK/ERR/STALL/DAT are routed to the owner. The state stays while the owner's CYC is 1.
  - Owner CYC low: next state IDLE; no grant is issued in that cycle.
  - A CYC high with STB low is still held (execute's settle beat).
- Non-owner (and the losing master in IDLE): stall_o=1, ack_o=0, err_o=0. dat_o always equals s_dat_i.
- No owner: s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o, s_sel_o are 0.
- Watchdog (TIMEOUT>0):
  - A counter increments each cycle the owner's CYC is 1 and s_ack_i|s_err_i is 0.
  - It clears on ACK, on ERR, or on leaving OWN_x.
  - At count==TIMEOUT: assert owner err_o=1 for exactly one cycle, force s_cyc_o=s_stb_o=0 that cycle, and clear the counter.
  - The counter is ceil(log2(TIMEOUT+1)) bits and never wraps.
- Reset mid-cycle: state goes to IDLE, `last`=I (so D wins the first contention), and the counter goes to 0. The slave sees CYC drop immediately.

## Timing
- Reset values while rst_n=0:
  - s_cyc_o=s_stb_o=s_we_o=0; s_adr_o, s_dat_o, s_sel_o = 0.
  - All ack_o/err_o = 0; both stall_o = 1. Grant logic is gated by rst_n.
- Grant latency: 0 cycles from CYC rise in IDLE.
- Release: 1 idle cycle (IDLE) between owners. Back-to-back alternation costs one cycle per handoff.
- Slave responses pass combinationally to the owner (0-cycle latency). No registers sit on the data or response path.
- Simultaneous owner-CYC-drop and other-CYC-rise: go to IDLE first; the other master is granted the following cycle.
- Simultaneous s_ack_i and watchdog expiry: ACK wins; the counter clears and no err is generated.

## Structure
- auv_pkg gains `arb_state_t` {ARB_IDLE, ARB_OWN_I, ARB_OWN_D} and `arb_master_t` {ARB_M_I, ARB_M_D}.
- One sub-module, auv_wb_watchdog: a counter with inputs busy, done, TIMEOUT parameter and a single-cycle expire output. It is instantiated once.

## Test plan
- D-only read: md_cyc=md_stb=1 in IDLE, slave ACK after 2 cycles with dat 16'hBEEF -> s_cyc_o same cycle, md_ack_o=1 and md_dat_o=16'hBEEF; mi_stall_o=1 throughout.
- Contention from reset: both CYC rise together -> D granted (last=I) and mi_stall_o=1. D drops CYC -> one IDLE cycle, then I granted.
- Word load (two beats, CYC held with an STB-low beat between) while I requests -> I is never granted until md_cyc drops; the slave sees both beats under one CYC.
- Watchdog with TIMEOUT=4: I owns the bus and the slave never ACKs -> mi_err_o=1 exactly on the 4th wait cycle, with s_cyc_o=0 in that cycle.
- ACK coincident with expiry, same setup with ACK on the 4th cycle -> mi_ack_o=1 and mi_err_o=0.
- rst_n asserted while D owns the bus mid-STB -> s_cyc_o=0 and both stalls=1 immediately. After release, a contention grants D first.
